// File: rtl/holy_axil_ram.sv
// holy_axil_ram: AXI-Lite slave scratchpad RAM.
//
// Word-organised RAM of DEPTH 32-bit words decoded from BASE_ADDR. The write
// and read channels each have their own two-state FSM and never stall each
// other. Writes are byte-strobed and commit on the edge where both AW and W
// are held. Reads are synchronous with one cycle of latency. Accesses outside
// [BASE_ADDR, BASE_ADDR + 4*DEPTH) answer SLVERR and never touch memory.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   s_axi_lite_aw*             write address channel (awaddr, awvalid, awready)
//   s_axi_lite_w*              write data channel (wdata, wstrb, wvalid, wready)
//   s_axi_lite_b*              write response channel (bresp, bvalid, bready)
//   s_axi_lite_ar*             read address channel (araddr, arvalid, arready)
//   s_axi_lite_r*              read data channel (rdata, rresp, rvalid, rready)
module holy_axil_ram #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 3072
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axi_lite_awaddr,
  input  logic        s_axi_lite_awvalid,
  output logic        s_axi_lite_awready,
  input  logic [31:0] s_axi_lite_wdata,
  input  logic [3:0]  s_axi_lite_wstrb,
  input  logic        s_axi_lite_wvalid,
  output logic        s_axi_lite_wready,
  output logic [1:0]  s_axi_lite_bresp,
  output logic        s_axi_lite_bvalid,
  input  logic        s_axi_lite_bready,
  input  logic [31:0] s_axi_lite_araddr,
  input  logic        s_axi_lite_arvalid,
  output logic        s_axi_lite_arready,
  output logic [31:0] s_axi_lite_rdata,
  output logic [1:0]  s_axi_lite_rresp,
  output logic        s_axi_lite_rvalid,
  input  logic        s_axi_lite_rready
);

  localparam int unsigned IdxW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] SpanBytes = 32'(4 * DEPTH);
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlverr = 2'b10;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  // Contents are deliberately not reset so data survives a reset pulse.
  logic [31:0] mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;

  logic            aw_hs, w_hs, commit;
  logic [31:0]     wr_addr, wr_data;
  logic [3:0]      wr_strb;
  logic [32:0]     wr_off;
  logic            wr_in_range;
  logic [IdxW-1:0] wr_idx;

  assign s_axi_lite_awready = !rst && (w_state_q == WIdle) && !aw_held_q;
  assign s_axi_lite_wready  = !rst && (w_state_q == WIdle) && !w_held_q;
  assign s_axi_lite_bvalid  = (w_state_q == WResp);
  assign s_axi_lite_bresp   = bresp_q;

  assign aw_hs = s_axi_lite_awvalid && s_axi_lite_awready;
  assign w_hs  = s_axi_lite_wvalid && s_axi_lite_wready;

  // A same-cycle handshake counts as held, so take the live bus value then.
  assign wr_addr = aw_hs ? s_axi_lite_awaddr : awaddr_q;
  assign wr_data = w_hs ? s_axi_lite_wdata : wdata_q;
  assign wr_strb = w_hs ? s_axi_lite_wstrb : wstrb_q;

  // Bit 32 of the offset is the borrow: set when the address is below the base.
  assign wr_off      = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
  assign wr_in_range = !wr_off[32] && (wr_off[31:0] < SpanBytes);
  assign wr_idx      = IdxW'(wr_off >> 2);

  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi_lite_awaddr;
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi_lite_wdata;
          wstrb_d  = s_axi_lite_wstrb;
        end
        if ((aw_held_q || aw_hs) && (w_held_q || w_hs)) begin
          commit    = 1'b1;
          bresp_d   = wr_in_range ? RespOkay : RespSlverr;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (s_axi_lite_bready) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= WIdle;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Readies are forced low during reset, so no commit can happen then.
  always_ff @(posedge clk) begin
    if (commit && wr_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  r_state_e        r_state_q, r_state_d;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            ar_hs;
  logic [32:0]     rd_off;
  logic            rd_in_range;
  logic [IdxW-1:0] rd_idx;

  assign s_axi_lite_arready = !rst && (r_state_q == RIdle);
  assign s_axi_lite_rvalid  = (r_state_q == RResp);
  assign s_axi_lite_rdata   = rdata_q;
  assign s_axi_lite_rresp   = rresp_q;

  assign ar_hs       = s_axi_lite_arvalid && s_axi_lite_arready;
  assign rd_off      = {1'b0, s_axi_lite_araddr} - {1'b0, BASE_ADDR};
  assign rd_in_range = !rd_off[32] && (rd_off[31:0] < SpanBytes);
  assign rd_idx      = IdxW'(rd_off >> 2);

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs) r_state_d = RResp;
      RResp:   if (s_axi_lite_rready) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  // Non-blocking read of mem gives the pre-commit word on a same-edge collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= RIdle;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_in_range ? mem[rd_idx] : 32'h0;
        rresp_q <= rd_in_range ? RespOkay : RespSlverr;
      end
    end
  end

endmodule

// File: tb/tb_holy_axil_ram.sv
// Self-checking bench for holy_axil_ram: directed scenarios followed by
// randomized traffic, checked against an associative-array memory model.
module tb_holy_axil_ram;

  localparam logic [31:0]     Base  = 32'h0000_0000;
  localparam int unsigned     Depth = 3072;
  localparam longint unsigned Span  = 4 * Depth;

  logic        clk;
  logic        rst;
  logic [31:0] s_axi_lite_awaddr;
  logic        s_axi_lite_awvalid;
  logic        s_axi_lite_awready;
  logic [31:0] s_axi_lite_wdata;
  logic [3:0]  s_axi_lite_wstrb;
  logic        s_axi_lite_wvalid;
  logic        s_axi_lite_wready;
  logic [1:0]  s_axi_lite_bresp;
  logic        s_axi_lite_bvalid;
  logic        s_axi_lite_bready;
  logic [31:0] s_axi_lite_araddr;
  logic        s_axi_lite_arvalid;
  logic        s_axi_lite_arready;
  logic [31:0] s_axi_lite_rdata;
  logic [1:0]  s_axi_lite_rresp;
  logic        s_axi_lite_rvalid;
  logic        s_axi_lite_rready;

  int n_chk;
  int n_fail;

  logic [31:0] model [int unsigned];

  holy_axil_ram #(
    .BASE_ADDR(Base),
    .DEPTH    (Depth)
  ) u_dut (
    .clk               (clk),
    .rst               (rst),
    .s_axi_lite_awaddr (s_axi_lite_awaddr),
    .s_axi_lite_awvalid(s_axi_lite_awvalid),
    .s_axi_lite_awready(s_axi_lite_awready),
    .s_axi_lite_wdata  (s_axi_lite_wdata),
    .s_axi_lite_wstrb  (s_axi_lite_wstrb),
    .s_axi_lite_wvalid (s_axi_lite_wvalid),
    .s_axi_lite_wready (s_axi_lite_wready),
    .s_axi_lite_bresp  (s_axi_lite_bresp),
    .s_axi_lite_bvalid (s_axi_lite_bvalid),
    .s_axi_lite_bready (s_axi_lite_bready),
    .s_axi_lite_araddr (s_axi_lite_araddr),
    .s_axi_lite_arvalid(s_axi_lite_arvalid),
    .s_axi_lite_arready(s_axi_lite_arready),
    .s_axi_lite_rdata  (s_axi_lite_rdata),
    .s_axi_lite_rresp  (s_axi_lite_rresp),
    .s_axi_lite_rvalid (s_axi_lite_rvalid),
    .s_axi_lite_rready (s_axi_lite_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: plain address arithmetic on byte addresses.
  function automatic bit in_rng(input logic [31:0] a);
    longint unsigned off;
    off = longint'(a) - longint'(Base);
    return off < Span;
  endfunction

  function automatic int unsigned widx(input logic [31:0] a);
    return int'((a - Base) / 4);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [31:0] w;
    if (!in_rng(a) || s == 4'h0) return;
    w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    model[widx(a)] = w;
  endfunction

  // aw_dly / w_dly: cycles before each valid is raised; b_dly: cycles bready is held low.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic       aw_fire, w_fire, aw_done, w_done;
    logic [1:0] exp_resp;
    int         c;
    @(posedge clk); #1;
    exp_resp          = in_rng(addr) ? 2'b00 : 2'b10;
    aw_done           = 1'b0;
    w_done            = 1'b0;
    c                 = 0;
    s_axi_lite_awaddr = addr;
    s_axi_lite_wdata  = data;
    s_axi_lite_wstrb  = strb;
    s_axi_lite_bready = 1'b0;
    while (!(aw_done && w_done) && c < 50) begin
      if (c >= aw_dly && !aw_done) s_axi_lite_awvalid = 1'b1;
      if (c >= w_dly && !w_done) s_axi_lite_wvalid = 1'b1;
      @(negedge clk);
      aw_fire = s_axi_lite_awvalid && s_axi_lite_awready;
      w_fire  = s_axi_lite_wvalid && s_axi_lite_wready;
      if (w_done && !aw_done) begin
        check_eq("awready_while_w_held", 32'(s_axi_lite_awready), 32'd1);
        check_eq("wready_while_w_held", 32'(s_axi_lite_wready), 32'd0);
      end
      if (aw_done && !w_done) begin
        check_eq("awready_while_aw_held", 32'(s_axi_lite_awready), 32'd0);
      end
      @(posedge clk); #1;
      if (aw_fire) begin s_axi_lite_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_fire) begin s_axi_lite_wvalid = 1'b0; w_done = 1'b1; end
      c++;
    end
    s_axi_lite_awvalid = 1'b0;
    s_axi_lite_wvalid  = 1'b0;
    check_eq("write_handshakes", {30'd0, aw_done, w_done}, 32'd3);
    @(negedge clk);
    check_eq("bvalid_latency", 32'(s_axi_lite_bvalid), 32'd1);
    check_eq("bresp", 32'(s_axi_lite_bresp), 32'(exp_resp));
    for (int i = 0; i < b_dly; i++) begin
      @(negedge clk);
      check_eq("bvalid_stall", 32'(s_axi_lite_bvalid), 32'd1);
      check_eq("bresp_stall", 32'(s_axi_lite_bresp), 32'(exp_resp));
      check_eq("aw_w_ready_stall", {30'd0, s_axi_lite_awready, s_axi_lite_wready}, 32'd0);
    end
    s_axi_lite_bready = 1'b1;
    @(posedge clk); #1;
    s_axi_lite_bready = 1'b0;
    @(negedge clk);
    check_eq("bvalid_cleared", 32'(s_axi_lite_bvalid), 32'd0);
    model_write(addr, data, strb);
  endtask

  task automatic do_read(input logic [31:0] addr, input int r_dly);
    logic        fired;
    logic [31:0] d0;
    int          c;
    @(posedge clk); #1;
    s_axi_lite_araddr  = addr;
    s_axi_lite_arvalid = 1'b1;
    s_axi_lite_rready  = 1'b0;
    fired              = 1'b0;
    c                  = 0;
    while (!fired && c < 50) begin
      @(negedge clk);
      fired = s_axi_lite_arvalid && s_axi_lite_arready;
      @(posedge clk); #1;
      c++;
    end
    s_axi_lite_arvalid = 1'b0;
    check_eq("ar_handshake", 32'(fired), 32'd1);
    @(negedge clk);
    check_eq("rvalid_latency", 32'(s_axi_lite_rvalid), 32'd1);
    if (!in_rng(addr)) begin
      check_eq("rresp_oor", 32'(s_axi_lite_rresp), 32'd2);
      check_eq("rdata_oor", s_axi_lite_rdata, 32'h0);
    end else begin
      check_eq("rresp", 32'(s_axi_lite_rresp), 32'd0);
      if (model.exists(widx(addr))) check_eq("rdata", s_axi_lite_rdata, model[widx(addr)]);
    end
    d0 = s_axi_lite_rdata;
    for (int i = 0; i < r_dly; i++) begin
      @(negedge clk);
      check_eq("rvalid_stall", 32'(s_axi_lite_rvalid), 32'd1);
      check_eq("rdata_stall", s_axi_lite_rdata, d0);
      check_eq("arready_stall", 32'(s_axi_lite_arready), 32'd0);
    end
    s_axi_lite_rready = 1'b1;
    @(posedge clk); #1;
    s_axi_lite_rready = 1'b0;
    @(negedge clk);
    check_eq("rvalid_cleared", 32'(s_axi_lite_rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    n_chk              = 0;
    n_fail             = 0;
    rst                = 1'b1;
    s_axi_lite_awaddr  = '0;
    s_axi_lite_awvalid = 1'b0;
    s_axi_lite_wdata   = '0;
    s_axi_lite_wstrb   = '0;
    s_axi_lite_wvalid  = 1'b0;
    s_axi_lite_bready  = 1'b0;
    s_axi_lite_araddr  = '0;
    s_axi_lite_arvalid = 1'b0;
    s_axi_lite_rready  = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_eq("rst_valids", {30'd0, s_axi_lite_bvalid, s_axi_lite_rvalid}, 32'd0);
    check_eq("rst_readies", {29'd0, s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready},
             32'd0);
    check_eq("rst_rdata", s_axi_lite_rdata, 32'h0);
    check_eq("rst_resps", {28'd0, s_axi_lite_bresp, s_axi_lite_rresp}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_readies", {29'd0, s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready},
             32'd7);

    // Same-cycle AW/W, then read back.
    do_write(32'h100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(32'h100, 0);
    // W three cycles ahead of AW, partial strobes.
    do_write(32'h100, 32'h1122_3344, 4'b0101, 3, 0, 0);
    check_eq("merge_model", model[widx(32'h100)], 32'hDE22_BE44);
    do_read(32'h100, 0);
    // AW ahead of W.
    do_write(32'h0, 32'hCAFE_F00D, 4'hF, 0, 2, 0);
    // Range boundaries.
    do_write(32'h3000, 32'h5555_5555, 4'hF, 0, 0, 0);
    do_read(32'h3000, 0);
    do_read(32'h0, 0);
    do_write(32'h2FFC, 32'h0BAD_CAFE, 4'hF, 0, 0, 0);
    do_read(32'h2FFC, 0);
    do_read(32'hFFFF_FFFC, 0);
    // Zero-strobe write leaves memory unchanged.
    do_write(32'h100, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    do_read(32'h100, 0);
    // Backpressure on both response channels.
    do_write(32'h104, 32'h0123_4567, 4'hF, 0, 0, 5);
    do_read(32'h104, 5);

    // Read and write committing to the same word on the same edge.
    do_write(32'h200, 32'h0, 4'hF, 0, 0, 0);
    @(posedge clk); #1;
    s_axi_lite_awaddr  = 32'h200;
    s_axi_lite_wdata   = 32'hA5A5_A5A5;
    s_axi_lite_wstrb   = 4'hF;
    s_axi_lite_araddr  = 32'h200;
    s_axi_lite_awvalid = 1'b1;
    s_axi_lite_wvalid  = 1'b1;
    s_axi_lite_arvalid = 1'b1;
    s_axi_lite_bready  = 1'b1;
    s_axi_lite_rready  = 1'b1;
    @(negedge clk);
    check_eq("collide_readies",
             {29'd0, s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready}, 32'd7);
    @(posedge clk); #1;
    s_axi_lite_awvalid = 1'b0;
    s_axi_lite_wvalid  = 1'b0;
    s_axi_lite_arvalid = 1'b0;
    @(negedge clk);
    check_eq("collide_valids", {30'd0, s_axi_lite_bvalid, s_axi_lite_rvalid}, 32'd3);
    check_eq("collide_old_data", s_axi_lite_rdata, 32'h0);
    @(posedge clk); #1;
    s_axi_lite_bready = 1'b0;
    s_axi_lite_rready = 1'b0;
    model_write(32'h200, 32'hA5A5_A5A5, 4'hF);
    do_read(32'h200, 0);

    // Reset while W is held and AW is pending.
    @(posedge clk); #1;
    s_axi_lite_wdata  = 32'h7777_7777;
    s_axi_lite_wstrb  = 4'hF;
    s_axi_lite_wvalid = 1'b1;
    @(negedge clk);
    check_eq("w_taken_before_rst", 32'(s_axi_lite_wready), 32'd1);
    @(posedge clk); #1;
    s_axi_lite_wvalid  = 1'b0;
    s_axi_lite_awaddr  = 32'h100;
    s_axi_lite_awvalid = 1'b1;
    rst                = 1'b1;
    @(negedge clk);
    check_eq("midrst_readies",
             {29'd0, s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready}, 32'd0);
    @(posedge clk); #1;
    s_axi_lite_awvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("postrst_valids", {30'd0, s_axi_lite_bvalid, s_axi_lite_rvalid}, 32'd0);
    check_eq("postrst_readies",
             {29'd0, s_axi_lite_awready, s_axi_lite_wready, s_axi_lite_arready}, 32'd7);
    do_read(32'h100, 0);
    do_read(32'h200, 0);
    do_read(32'h0, 0);

    // Randomized traffic over a small window plus occasional out-of-range hits.
    for (int i = 0; i < 16; i++) do_write(32'h1000 + 32'(4 * i), $urandom, 4'hF, 0, 0, 0);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) a = 32'h3000 + 32'(4 * $urandom_range(0, 1023));
      else a = 32'h1000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/holy_axil_ram.md
Name: holy_axil_ram

Overview:
- AXI-Lite slave scratchpad RAM that sits on one crossbar master port of the SoC, directly downstream of the AXI-Lite crossbar.
- It is the synthesizable replacement for the simulated external data RAM, mapped at 0x0000-0x2FFF.
- It has independent write and read channel FSMs, byte-strobed writes and single-cycle synchronous reads.
- Out-of-range accesses return SLVERR.

Parameters:
- BASE_ADDR, 32'h0000_0000: first byte address decoded by the block.
- DEPTH, 3072: number of 32-bit words. Byte span is 4*DEPTH.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_axi_lite_awaddr  in  32  write address.
- s_axi_lite_awvalid  in  1  write address valid.
- s_axi_lite_awready  out  1  write address ready.
- s_axi_lite_wdata  in  32  write data.
- s_axi_lite_wstrb  in  4  byte strobes; bit i enables byte i.
- s_axi_lite_wvalid  in  1  write data valid.
- s_axi_lite_wready  out  1  write data ready.
- s_axi_lite_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_lite_bvalid  out  1  write response valid.
- s_axi_lite_bready  in  1  write response ready.
- s_axi_lite_araddr  in  32  read address.
- s_axi_lite_arvalid  in  1  read address valid.
- s_axi_lite_arready  out  1  read address ready.
- s_axi_lite_rdata  out  32  read data.
- s_axi_lite_rresp  out  2  read response: 2'b00 OKAY, 2'b10 SLVERR.
- s_axi_lite_rvalid  out  1  read data valid.
- s_axi_lite_rready  in  1  read data ready.

Behaviour:
- Reset (async assert, sync release):
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - All ready outputs are 0 while rst=1.
  - Write FSM goes to W_IDLE with aw_held=0 and w_held=0. Read FSM goes to R_IDLE.
  - Memory contents are NOT cleared; they are retained across reset.
- Address decode:
  - in_range = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*DEPTH).
  - Word index = (addr - BASE_ADDR) >> 2; addr[1:0] are ignored.
- Write FSM, states W_IDLE and W_RESP:
  - W_IDLE: awready = !aw_held; wready = !w_held.
  - AW and W are accepted independently and in any order, including both in the same cycle. Captured address/data/strb are stored in registers.
  - Transition to W_RESP occurs at the edge where both become held, counting the same-cycle handshake as held.
  - At that same edge, if in_range, each byte with strb=1 is written. bresp = in_range ? OKAY : SLVERR. Out-of-range and all-zero strobe writes leave memory unchanged.
  - W_RESP: bvalid=1, awready=0, wready=0. bvalid/bresp are held stable until bready.
  - On the bvalid&&bready edge: clear both held flags and return to W_IDLE.
  - Minimum latency: bvalid in cycle N+1 after the last of AW/W handshakes in cycle N. Throughput is 1 write per 2 cycles.
- Read FSM, states R_IDLE and R_RESP:
  - R_IDLE: arready=1.
  - On arvalid&&arready in cycle N: rdata <= in_range ? mem[idx] : 32'h0; rresp <= in_range ? OKAY : SLVERR. Go to R_RESP.
  - R_RESP: rvalid=1, arready=0. rdata/rresp are held stable until rready.
  - On the rvalid&&rready edge: rvalid=0 and return to R_IDLE. No read bypass or back-to-back in the same cycle.
- Read/write collision: a read accepted in the same cycle that a write commits to the same word returns the OLD word (read-before-write). The next read sees the new data.
- The read and write channels are fully independent; neither FSM stalls the other.
- Valid signals never depend combinationally on ready inputs. Ready outputs depend only on state and held flags (plus rst).
- Reset asserted mid-transaction:
  - Any pending response is dropped and captured AW/W are discarded.
  - A write that had not reached its commit edge does not modify memory.

Test Plan:
- Reset, then AW(0x100) and W(0xDEADBEEF, strb 4'hF) in the same cycle, bready=1 -> bvalid the next cycle with bresp=00. Read 0x100 -> rvalid 1 cycle after AR with rdata=0xDEADBEEF, rresp=00.
- W (0x11223344, strb 4'b0101) presented 3 cycles before AW(0x100), over prior word 0xDEADBEEF -> awready stays 1 and wready=0 while W is held. After the AW handshake, bvalid follows, and a read returns 0xDE22BE44.
- Write to 0x3000 (DEPTH=3072) -> bresp=10 and memory unchanged. Read 0x3000 -> rresp=10, rdata=0. Read 0x2FFC -> OKAY.
- Hold bready=0 for 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout. Hold rready=0 likewise -> rdata stable, arready=0.
- A write committing to 0x200 (old 0x0, new 0xA5A5A5A5) in the same cycle as a read of 0x200 is accepted -> the read returns 0x0 and a subsequent read returns 0xA5A5A5A5.
- Assert rst while W is held and AW is pending -> after release, all valids are 0 and readies are 1. The target word is unchanged, and earlier-written words are retained.
